// File: rtl/synth_kbd_pkg.sv
// Shared constants, parser state type and scan-code helpers for the
// keyboard synthesizer front end.
package synth_kbd_pkg;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_FREE  = 8'hF0;
    localparam int         NUM_CH   = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK
    } parser_state_t;

    // Keyboard status/response bytes that never start a key event.
    function automatic logic is_ignored(input logic [7:0] code);
        logic ign;
        case (code)
            8'h00, 8'hAA, 8'hEE, 8'hFA,
            8'hFC, 8'hFD, 8'hFE, 8'hFF: ign = 1'b1;
            default:                    ign = 1'b0;
        endcase
        return ign;
    endfunction

endpackage

// File: rtl/ps2_prefix_parser.sv
// PS/2 byte parser: tracks E0/F0 prefixes, discards extended keys and
// stale prefixes, and emits registered one-cycle make/break strobes.
module ps2_prefix_parser #(
    parameter int PREFIX_TIMEOUT = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       make_stb,
    output logic       break_stb,
    output logic [7:0] code
);
    import synth_kbd_pkg::*;

    localparam int CNT_W = (PREFIX_TIMEOUT > 1) ? $clog2(PREFIX_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PREFIX_TIMEOUT - 1);

    parser_state_t    state;
    logic [CNT_W-1:0] cnt;

    // Prefix FSM with idle timeout; strobes are registered and last one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            make_stb  <= 1'b0;
            break_stb <= 1'b0;
        end else begin
            make_stb  <= 1'b0;
            break_stb <= 1'b0;
            if (rx_valid) begin
                // Every byte seen outside IDLE changes state, so the
                // counter can simply restart on any byte.
                cnt <= '0;
                case (state)
                    ST_IDLE: begin
                        if (rx_data == SC_EXT) begin
                            state <= ST_EXT;
                        end else if (rx_data == SC_BREAK) begin
                            state <= ST_BRK;
                        end else if (!is_ignored(rx_data)) begin
                            make_stb <= 1'b1;
                            code     <= rx_data;
                        end
                    end
                    ST_EXT: begin
                        state <= (rx_data == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
                    end
                    ST_BRK: begin
                        state <= ST_IDLE;
                        if (rx_data != SC_EXT && rx_data != SC_BREAK) begin
                            break_stb <= 1'b1;
                            code      <= rx_data;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end else if (state != ST_IDLE) begin
                if (cnt == CNT_LAST) begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ps2_voice_alloc.sv
// PS/2 keyboard voice allocator: parses key events and assigns held keys
// to four voice channels (8'hF0 marks a free channel).
// Optional build macro VOICE_STEAL_EN: when defined, a make with all
// channels busy steals the oldest channel instead of being dropped.
module ps2_voice_alloc #(
    parameter int NUM_CH         = 4,
    parameter int PREFIX_TIMEOUT = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] scan_code1,
    output logic [7:0] scan_code2,
    output logic [7:0] scan_code3,
    output logic [7:0] scan_code4,
    output logic [3:0] ch_busy,
    output logic       overflow
);
    import synth_kbd_pkg::*;

    localparam int IDX_W = $clog2(NUM_CH);

    logic                      make_stb;
    logic                      break_stb;
    logic [7:0]                code;
    logic [NUM_CH-1:0][7:0]    chan;
    logic [NUM_CH-1:0]         busy;
    logic [NUM_CH-1:0]         hit;
    logic                      any_free;
    logic [IDX_W-1:0]          free_idx;

    ps2_prefix_parser #(
        .PREFIX_TIMEOUT(PREFIX_TIMEOUT)
    ) u_parser (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .make_stb  (make_stb),
        .break_stb (break_stb),
        .code      (code)
    );

    // Channel occupancy, code matches and lowest-numbered free channel.
    always_comb begin
        any_free = 1'b0;
        free_idx = '0;
        busy     = '0;
        hit      = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            busy[i] = (chan[i] != SC_FREE);
            hit[i]  = busy[i] && (chan[i] == code);
            if (!busy[i]) begin
                any_free = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

`ifdef VOICE_STEAL_EN
    logic [NUM_CH-1:0][1:0] age;
    logic [IDX_W-1:0]       old_idx;
    logic [1:0]             old_age;

    // Oldest channel by allocation age; strict compare keeps ties on the lowest index.
    always_comb begin
        old_idx = '0;
        old_age = age[0];
        for (int i = 1; i < NUM_CH; i++) begin
            if (age[i] > old_age) begin
                old_idx = IDX_W'(i);
                old_age = age[i];
            end
        end
    end

    // Allocation ages: the newly loaded channel restarts, other busy ones age up to 3.
    always_ff @(posedge clk) begin
        if (reset) begin
            age <= '0;
        end else if (make_stb && !(|hit)) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (IDX_W'(i) == (any_free ? free_idx : old_idx)) begin
                    age[i] <= 2'd0;
                end else if (busy[i] && age[i] != 2'd3) begin
                    age[i] <= age[i] + 2'd1;
                end
            end
        end else if (break_stb) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (hit[i]) begin
                    age[i] <= 2'd0;
                end
            end
        end
    end
`endif

    // Channel table, busy flags and overflow pulse; written only on make/break/reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                chan[i] <= SC_FREE;
            end
            ch_busy  <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= 1'b0;
            if (make_stb) begin
                if (|hit) begin
                    // Typematic repeat of a key already sounding.
                end else if (any_free) begin
                    chan[free_idx]    <= code;
                    ch_busy[free_idx] <= 1'b1;
                end else begin
                    overflow <= 1'b1;
`ifdef VOICE_STEAL_EN
                    chan[old_idx] <= code;
`endif
                end
            end else if (break_stb) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (hit[i]) begin
                        chan[i]    <= SC_FREE;
                        ch_busy[i] <= 1'b0;
                    end
                end
            end
        end
    end

    assign scan_code1 = chan[0];
    assign scan_code2 = chan[1];
    assign scan_code3 = chan[2];
    assign scan_code4 = chan[3];

endmodule

// File: tb/tb_ps2_voice_alloc.sv
// Self-checking bench for ps2_voice_alloc: directed test-plan steps plus a
// randomized byte stream checked every cycle against a key-event model.
module tb_ps2_voice_alloc;

    localparam int P = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic [7:0] scan_code1, scan_code2, scan_code3, scan_code4;
    logic [3:0] ch_busy;
    logic       overflow;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    logic [7:0] m_ch [4];
    int         m_age [4];
    bit         m_ovf;
    bit         pend_ext, pend_brk;
    int         idle_cnt;
    int         act;        // 0 none, 1 make, 2 break (takes effect next cycle)
    logic [7:0] act_code;

    ps2_voice_alloc #(.NUM_CH(4), .PREFIX_TIMEOUT(P)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .scan_code1 (scan_code1),
        .scan_code2 (scan_code2),
        .scan_code3 (scan_code3),
        .scan_code4 (scan_code4),
        .ch_busy    (ch_busy),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    function automatic bit ign(input logic [7:0] b);
        return (b == 8'h00) || (b == 8'hAA) || (b == 8'hEE) || (b == 8'hFA) ||
               (b == 8'hFC) || (b == 8'hFD) || (b == 8'hFE) || (b == 8'hFF);
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 4; i++) begin
            m_ch[i]  = 8'hF0;
            m_age[i] = 0;
        end
        m_ovf = 0; pend_ext = 0; pend_brk = 0; idle_cnt = 0; act = 0; act_code = 8'h00;
    endtask

    task automatic m_alloc(input int t, input logic [7:0] c);
        for (int i = 0; i < 4; i++)
            if (i != t && m_ch[i] != 8'hF0 && m_age[i] < 3) m_age[i]++;
        m_age[t] = 0;
        m_ch[t]  = c;
    endtask

    task automatic m_apply();
        bit held;
        int fr, old;
        if (act == 1) begin
            held = 0; fr = -1;
            for (int i = 0; i < 4; i++) if (m_ch[i] == act_code) held = 1;
            for (int i = 3; i >= 0; i--) if (m_ch[i] == 8'hF0) fr = i;
            if (!held) begin
                if (fr >= 0) m_alloc(fr, act_code);
                else begin
                    m_ovf = 1;
`ifdef VOICE_STEAL_EN
                    old = 0;
                    for (int i = 1; i < 4; i++) if (m_age[i] > m_age[old]) old = i;
                    m_alloc(old, act_code);
`else
                    old = 0;
`endif
                end
            end
        end else if (act == 2) begin
            for (int i = 0; i < 4; i++)
                if (m_ch[i] == act_code) begin
                    m_ch[i] = 8'hF0; m_age[i] = 0;
                end
        end
        act = 0;
    endtask

    task automatic m_byte(input logic [7:0] b);
        idle_cnt = 0;
        if (!pend_ext && !pend_brk) begin
            if (b == 8'hE0) pend_ext = 1;
            else if (b == 8'hF0) pend_brk = 1;
            else if (!ign(b)) begin act = 1; act_code = b; end
        end else if (pend_ext) begin
            if (!pend_brk && b == 8'hF0) pend_brk = 1;
            else begin pend_ext = 0; pend_brk = 0; end
        end else begin
            if (b != 8'hE0 && b != 8'hF0) begin act = 2; act_code = b; end
            pend_brk = 0;
        end
    endtask

    task automatic check_model(input string tag);
        logic [3:0] eb;
        for (int i = 0; i < 4; i++) eb[i] = (m_ch[i] != 8'hF0);
        chk({tag, ".sc1"}, scan_code1, m_ch[0]);
        chk({tag, ".sc2"}, scan_code2, m_ch[1]);
        chk({tag, ".sc3"}, scan_code3, m_ch[2]);
        chk({tag, ".sc4"}, scan_code4, m_ch[3]);
        chk({tag, ".busy"}, {4'h0, ch_busy}, {4'h0, eb});
        chk({tag, ".ovf"}, {7'h0, overflow}, {7'h0, m_ovf});
    endtask

    // One clock cycle: drive inputs, advance past the edge, update model, compare.
    task automatic cycle(input bit v, input logic [7:0] b, input bit r);
        rx_valid = v;
        rx_data  = v ? b : 8'h00;
        reset    = r;
        @(negedge clk);
        if (r) m_reset();
        else begin
            m_ovf = 0;
            m_apply();
            if (v) m_byte(b);
            else if (pend_ext || pend_brk) begin
                idle_cnt++;
                if (idle_cnt == P) begin pend_ext = 0; pend_brk = 0; idle_cnt = 0; end
            end
        end
        check_model("model");
    endtask

    task automatic send(input logic [7:0] b);
        cycle(1'b1, b, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0);
    endtask

    task automatic do_reset();
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        m_reset();
        @(negedge clk);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        chk("rst.sc1", scan_code1, 8'hF0);
        chk("rst.sc4", scan_code4, 8'hF0);
        chk("rst.busy", {4'h0, ch_busy}, 8'h00);
        chk("rst.ovf", {7'h0, overflow}, 8'h00);
        cycle(1'b0, 8'h00, 1'b0);

        // Three makes fill channels 1..3 in order, one cycle after each byte
        send(8'h1C);
        chk("lat.sc1_before", scan_code1, 8'hF0);
        idle(1);
        chk("lat.sc1_after", scan_code1, 8'h1C);
        send(8'h1B); idle(1);
        send(8'h23); idle(1);
        chk("fill3.sc1", scan_code1, 8'h1C);
        chk("fill3.sc2", scan_code2, 8'h1B);
        chk("fill3.sc3", scan_code3, 8'h23);
        chk("fill3.sc4", scan_code4, 8'hF0);
        chk("fill3.busy", {4'h0, ch_busy}, 8'h07);

        // Break frees only its channel; next make takes the lowest free one
        do_reset();
        send(8'h1C); send(8'h1B); send(8'hF0); send(8'h1C); idle(1);
        chk("brk.sc1", scan_code1, 8'hF0);
        chk("brk.sc2", scan_code2, 8'h1B);
        send(8'h2B); idle(1);
        chk("refill.sc1", scan_code1, 8'h2B);

        // Fifth key with all channels busy
        do_reset();
        send(8'h1C); send(8'h1B); send(8'h23); send(8'h2B); send(8'h34); idle(1);
        chk("ovf.pulse", {7'h0, overflow}, 8'h01);
`ifdef VOICE_STEAL_EN
        chk("ovf.sc1", scan_code1, 8'h34);
`else
        chk("ovf.sc1", scan_code1, 8'h1C);
`endif
        chk("ovf.sc4", scan_code4, 8'h2B);
        idle(1);
        chk("ovf.one_cycle", {7'h0, overflow}, 8'h00);

        // Typematic repeats and extended keys
        do_reset();
        send(8'h1C); send(8'h1C); send(8'h1C); idle(1);
        chk("typ.busy", {4'h0, ch_busy}, 8'h01);
        chk("typ.sc2", scan_code2, 8'hF0);
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75); idle(1);
        chk("ext.busy", {4'h0, ch_busy}, 8'h01);
        chk("ext.sc1", scan_code1, 8'h1C);

        // Prefix timeout boundary: P-1 idle cycles keep the F0, P cycles drop it
        send(8'hF0); idle(P - 1); send(8'h1C); idle(1);
        chk("to.short_is_break", scan_code1, 8'hF0);
        send(8'hF0); idle(P); send(8'h1C); idle(1);
        chk("to.expired_is_make", scan_code1, 8'h1C);

        // Reset mid-way through a break sequence
        do_reset();
        send(8'h1C); send(8'h1B); idle(1); send(8'hF0);
        cycle(1'b1, 8'h1C, 1'b1);
        chk("mrst.sc1", scan_code1, 8'hF0);
        chk("mrst.sc2", scan_code2, 8'hF0);
        chk("mrst.busy", {4'h0, ch_busy}, 8'h00);
        send(8'h1C); idle(1);
        chk("mrst.make", scan_code1, 8'h1C);

        // Reset while a make strobe is in flight
        send(8'h23);
        cycle(1'b0, 8'h00, 1'b1);
        chk("rst_inflight.sc2", scan_code2, 8'hF0);
        idle(2);

        // Randomized byte stream, checked against the model every cycle
        for (int n = 0; n < 1500; n++) begin
            int r;
            logic [7:0] pool [10];
            pool = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'hF0, 8'hF0, 8'hE0, 8'hAA, 8'h33};
            r = $urandom_range(0, 99);
            if (r < 2) idle(P + $urandom_range(0, 3));
            else if (r < 3) cycle(1'b0, 8'h00, 1'b1);
            else if (r < 70) send(pool[$urandom_range(0, 9)]);
            else idle(1);
        end
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_voice_alloc.md
Name: ps2_voice_alloc

Overview:
- Upstream neighbour of the four-channel keyboard synthesizer display/pitch stage.
- Consumes raw PS/2 keyboard bytes from the PS/2 receiver, parses make/break/extended prefixes, and allocates held keys to four voice channels.
- Drives scan_code1..4, which the pitch stage decodes.
- A channel holding 8'hF0 is free/silent; any other value is the held key's make code.

Parameters:
- NUM_CH, 4, number of voice channels; the outputs are fixed at four, so only 4 is supported.
- PREFIX_TIMEOUT, 1000000, clk cycles a pending prefix (E0/F0) waits for its following byte before being discarded (20 ms at 50 MHz).

Ports:
- clk  input  1  system clock; single clock domain.
- reset  input  1  synchronous, active-high reset.
- rx_data  input  8  byte from PS/2 receiver.
- rx_valid  input  1  one-cycle strobe; rx_data is valid when high.
- scan_code1  output  8  channel-1 held make code, 8'hF0 when free.
- scan_code2  output  8  channel-2, same encoding.
- scan_code3  output  8  channel-3, same encoding.
- scan_code4  output  8  channel-4, same encoding.
- ch_busy  output  4  bit i = channel i+1 holds a key.
- overflow  output  1  one-cycle pulse when a make code is dropped for lack of a free channel.

Behaviour:
- Reset: scan_code1..4 = 8'hF0, ch_busy = 0, overflow = 0, parser in IDLE, timeout counter 0. Reset mid-sequence discards any pending prefix and releases all channels.
- Parser FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen). Transitions happen only on rx_valid.
  - IDLE: E0 -> EXT; F0 -> BRK; ignored code -> IDLE; otherwise make(code).
  - EXT: F0 -> EXT_BRK; any other byte -> IDLE, discarded (extended keys are not voiced).
  - BRK: E0/F0 -> IDLE, discarded; otherwise break(code) -> IDLE.
  - EXT_BRK: any byte -> IDLE, discarded.
- Ignored codes in IDLE: 8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF.
- Timeout: in EXT, BRK or EXT_BRK, count cycles without rx_valid. When the count reaches PREFIX_TIMEOUT-1, go to IDLE. The counter clears on every state change. Counter width is $clog2(PREFIX_TIMEOUT).
- make(code):
  - If any channel already holds code (typematic repeat), nothing changes.
  - Else the lowest-numbered free channel is loaded with code.
  - Else (all busy): no channel change and overflow pulses high for exactly one cycle.
- break(code): every channel holding code is set to 8'hF0. If no channel matches, nothing changes.
- Latency: outputs update on the clk edge after the edge sampling the terminating byte (1 cycle). ch_busy[i] is registered in the same cycle as scan_code(i+1) and always equals scan_code(i+1) != 8'hF0.
- Back-to-back rx_valid on consecutive cycles must be handled with no byte lost.
- The channel table is written only on make/break/reset.

Optional Feature:
- Macro: VOICE_STEAL_EN.
- Defined:
  - Each channel keeps a 2-bit allocation age. A new allocation sets that channel to 0 and increments all other busy channels' ages, saturating at 3.
  - A make with all channels busy replaces the oldest channel (highest age; ties go to the lowest index). That channel's age resets to 0, and overflow still pulses.
  - Break does not alter other channels' ages.
- Undefined: make with all channels busy is dropped as described in Behaviour; no age logic is synthesized.

Decomposition:
- Package synth_kbd_pkg holds:
  - constants SC_BREAK=8'hF0, SC_EXT=8'hE0, SC_FREE=8'hF0, NUM_CH=4;
  - the ignored-code list as a function is_ignored(byte);
  - the parser state enum.
- One sub-module, ps2_prefix_parser: FSM plus timeout counter. It emits one-cycle make_stb/break_stb with an 8-bit code. The top level holds the channel table, the allocator and the optional stealing logic.

Test Plan:
- Reset, then bytes 1C, 1B, 23 -> scan_code1=1C, scan_code2=1B, scan_code3=23, scan_code4=F0, ch_busy=4'b0111, each visible one cycle after its byte.
- Hold 1C, 1B; send F0 1C -> scan_code1=F0 and scan_code2 stays 1B. Then send 2B -> scan_code1=2B (lowest free).
- Fill 1C 1B 23 2B, then send 34 -> overflow pulses 1 cycle and all channels are unchanged. With VOICE_STEAL_EN -> scan_code1=34 (oldest).
- Send 1C 1C 1C (typematic) -> only scan_code1=1C, ch_busy=4'b0001. Send E0 75 and E0 F0 75 -> no change.
- Send F0, idle PREFIX_TIMEOUT cycles, then 1C -> 1C is treated as a make and scan_code1=1C.
- Hold 1C 1B, assert reset mid-way through F0 1C -> all outputs F0 and ch_busy=0 on the next edge. A post-reset 1C is a make.
